wb_arbiter: RTL and testbench

//  Write-back stage directly upstream of the register file. Merges results from the ALU
//  (single-cycle) and the memory/long-latency unit onto the regfile's single write port
//  (rd_num/rd_data/rd_we). Keeps a per-register pending-write scoreboard for hazard

---
 rtl/wb_pkg.sv | 10 +
 rtl/rr_arbiter2.sv | 41 ++++
 rtl/wb_arbiter.sv | 104 ++++++++++
 tb/tb_wb_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and widths for the write-back arbiter
package wb_pkg;

   typedef enum logic [1:0] {RUN, DRAIN, HALTED} wb_state_t;
   typedef enum logic {SRC_ALU, SRC_MEM} wb_src_t;

   localparam int NREG_DEF  = 32;
   localparam int REG_IDX_W = $clog2(NREG_DEF);

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-request round-robin arbiter
// The regfile accepts every cycle, so a grant is a transfer and moves the pointer.
module rr_arbiter2
   import wb_pkg::*;
(
   input  logic clk,
   input  logic rst_b,
   input  logic en,
   input  logic req_alu,
   input  logic req_mem,
   output logic gnt_alu,
   output logic gnt_mem
);

   wb_src_t rr_last;

   always_comb begin
      gnt_alu = 1'b0;
      gnt_mem = 1'b0;
      if (en) begin
         if (req_alu && req_mem) begin
            gnt_alu = (rr_last == SRC_MEM);
            gnt_mem = (rr_last == SRC_ALU);
         end else begin
            gnt_alu = req_alu;
            gnt_mem = req_mem;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         rr_last <= SRC_MEM;
      end else if (gnt_alu) begin
         rr_last <= SRC_ALU;
      end else if (gnt_mem) begin
         rr_last <= SRC_MEM;
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - write-back merge of ALU and mem results onto the regfile port
// Also tracks outstanding mem writes and sequences halt behind the last commit.
module wb_arbiter
   import wb_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int NREG = 32
) (
   input  logic                     clk,
   input  logic                     rst_b,
   input  logic                     alu_valid,
   output logic                     alu_ready,
   input  logic [$clog2(NREG)-1:0]  alu_rd,
   input  logic [XLEN-1:0]          alu_data,
   input  logic                     mem_valid,
   output logic                     mem_ready,
   input  logic [$clog2(NREG)-1:0]  mem_rd,
   input  logic [XLEN-1:0]          mem_data,
   input  logic                     issue_valid,
   input  logic [$clog2(NREG)-1:0]  issue_rd,
   output logic [NREG-1:0]          busy,
   output logic [$clog2(NREG)-1:0]  rd_num,
   output logic [XLEN-1:0]          rd_data,
   output logic                     rd_we,
   input  logic                     halt_req,
   output logic                     halted
);

   localparam int IW = $clog2(NREG);

   wb_state_t       state, state_next;
   logic [NREG-1:0] busy_next;
   logic            alu_xfer, mem_xfer;

   rr_arbiter2 u_rr (
      .clk     (clk),
      .rst_b   (rst_b),
      .en      (state != HALTED),
      .req_alu (alu_valid),
      .req_mem (mem_valid),
      .gnt_alu (alu_ready),
      .gnt_mem (mem_ready)
   );

   assign alu_xfer = alu_valid && alu_ready;
   assign mem_xfer = mem_valid && mem_ready;
   assign halted   = (state == HALTED);

   // Clear first so a same-cycle issue to the same register wins.
   always_comb begin
      busy_next = busy;
      if (mem_xfer) begin
         busy_next[mem_rd] = 1'b0;
      end
      if (issue_valid && (issue_rd != '0) && (state != HALTED)) begin
         busy_next[issue_rd] = 1'b1;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         RUN: begin
            if (halt_req) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if ((busy == '0) && !alu_valid && !mem_valid && !rd_we) begin
               state_next = HALTED;
            end
         end
         default: state_next = HALTED;
      endcase
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state   <= RUN;
         busy    <= '0;
         rd_we   <= 1'b0;
         rd_num  <= '0;
         rd_data <= '0;
      end else begin
         state <= state_next;
         busy  <= busy_next;
         rd_we <= 1'b0;
         // r0 results are consumed without touching the write port.
         if (alu_xfer && (alu_rd != '0)) begin
            rd_we   <= 1'b1;
            rd_num  <= alu_rd;
            rd_data <= alu_data;
         end else if (mem_xfer && (mem_rd != '0)) begin
            rd_we   <= 1'b1;
            rd_num  <= mem_rd;
            rd_data <= mem_data;
         end
      end
   end

   logic [IW-1:0] unused_iw;
   assign unused_iw = '0;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed self-checking bench for wb_arbiter
module tb_wb_arbiter;
   import wb_pkg::*;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int IW   = REG_IDX_W;

   logic            clk = 1'b0;
   logic            rst_b;
   logic            alu_valid, mem_valid, issue_valid, halt_req;
   logic            alu_ready, mem_ready, rd_we, halted;
   logic [IW-1:0]   alu_rd, mem_rd, issue_rd, rd_num;
   logic [XLEN-1:0] alu_data, mem_data, rd_data;
   logic [NREG-1:0] busy;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   wb_arbiter #(.XLEN(XLEN), .NREG(NREG)) dut (
      .clk         (clk),
      .rst_b       (rst_b),
      .alu_valid   (alu_valid),
      .alu_ready   (alu_ready),
      .alu_rd      (alu_rd),
      .alu_data    (alu_data),
      .mem_valid   (mem_valid),
      .mem_ready   (mem_ready),
      .mem_rd      (mem_rd),
      .mem_data    (mem_data),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .busy        (busy),
      .rd_num      (rd_num),
      .rd_data     (rd_data),
      .rd_we       (rd_we),
      .halt_req    (halt_req),
      .halted      (halted)
   );

   typedef struct {
      logic        av;   logic [4:0] ard;  logic [31:0] adat;
      logic        mv;   logic [4:0] mrd;  logic [31:0] mdat;
      logic        iv;   logic [4:0] ird;
      logic        e_ar; logic e_mr;
      logic        e_we; logic chk_out; logic [4:0] e_num; logic [31:0] e_dat;
      logic [31:0] e_busy;
   } vec_t;

   localparam int NV = 14;
   vec_t v [NV];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle();
      alu_valid = 0; alu_rd = '0; alu_data = '0;
      mem_valid = 0; mem_rd = '0; mem_data = '0;
      issue_valid = 0; issue_rd = '0; halt_req = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issuing to a register that is already busy is illegal for the upstream decoder.
   always @(negedge clk) begin
      if (rst_b && issue_valid && issue_rd != '0 && busy[issue_rd]) begin
         errors++;
         $display("FAIL issue_to_busy: reg %0d already busy", issue_rd);
      end
   end

   initial begin
      //            av ard adat      mv mrd mdat      iv ird  ar mr we co num dat       busy
      v[0]  = '{0, 0, 0,         0, 0, 0,         0, 0,  0, 0, 0, 1, 0, 0,         32'h0};
      v[1]  = '{1, 1, 32'hA1,    1, 2, 32'hB2,    0, 0,  1, 0, 1, 1, 1, 32'hA1,    32'h0};
      v[2]  = '{1, 1, 32'hA1,    1, 2, 32'hB2,    0, 0,  0, 1, 1, 1, 2, 32'hB2,    32'h0};
      v[3]  = '{1, 1, 32'hA1,    1, 2, 32'hB2,    0, 0,  1, 0, 1, 1, 1, 32'hA1,    32'h0};
      v[4]  = '{1, 1, 32'hA1,    1, 2, 32'hB2,    0, 0,  0, 1, 1, 1, 2, 32'hB2,    32'h0};
      v[5]  = '{1, 3, 32'h11,    0, 0, 0,         0, 0,  1, 0, 1, 1, 3, 32'h11,    32'h0};
      v[6]  = '{0, 0, 0,         0, 0, 0,         0, 0,  0, 0, 0, 1, 3, 32'h11,    32'h0};
      v[7]  = '{0, 0, 0,         0, 0, 0,         1, 5,  0, 0, 0, 1, 3, 32'h11,    32'h20};
      v[8]  = '{0, 0, 0,         0, 0, 0,         1, 0,  0, 0, 0, 1, 3, 32'h11,    32'h20};
      v[9]  = '{0, 0, 0,         1, 5, 32'h55,    0, 0,  0, 1, 1, 1, 5, 32'h55,    32'h0};
      v[10] = '{0, 0, 0,         1, 7, 32'h77,    1, 7,  0, 1, 1, 1, 7, 32'h77,    32'h80};
      v[11] = '{0, 0, 0,         1, 7, 32'h78,    0, 0,  0, 1, 1, 1, 7, 32'h78,    32'h0};
      v[12] = '{1, 0, 32'h99,    0, 0, 0,         0, 0,  1, 0, 0, 0, 0, 0,         32'h0};
      v[13] = '{1, 4, 32'h44,    1, 6, 32'h66,    0, 0,  0, 1, 1, 1, 6, 32'h66,    32'h0};

      idle();
      rst_b = 0;
      #2;
      chk("reset_rd_we", rd_we, 0);
      chk("reset_rd_num", rd_num, 0);
      chk("reset_rd_data", rd_data, 0);
      chk("reset_busy", busy, 0);
      chk("reset_halted", halted, 0);
      #10 rst_b = 1;
      step();

      for (int i = 0; i < NV; i++) begin
         alu_valid = v[i].av; alu_rd = v[i].ard; alu_data = v[i].adat;
         mem_valid = v[i].mv; mem_rd = v[i].mrd; mem_data = v[i].mdat;
         issue_valid = v[i].iv; issue_rd = v[i].ird;
         #1;
         chk($sformatf("v%0d_alu_ready", i), alu_ready, v[i].e_ar);
         chk($sformatf("v%0d_mem_ready", i), mem_ready, v[i].e_mr);
         step();
         chk($sformatf("v%0d_rd_we", i), rd_we, v[i].e_we);
         if (v[i].chk_out) begin
            chk($sformatf("v%0d_rd_num", i), rd_num, v[i].e_num);
            chk($sformatf("v%0d_rd_data", i), rd_data, v[i].e_dat);
         end
         chk($sformatf("v%0d_busy", i), busy, v[i].e_busy);
      end
      idle();
      step();

      // Halt waits for an outstanding mem write to r9.
      issue_valid = 1; issue_rd = 9;
      step();
      idle();
      chk("drain_busy9", busy, 32'h200);
      halt_req = 1;
      step();
      halt_req = 0;
      chk("drain_halted_0", halted, 0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("drain_wait%0d_halted", i), halted, 0);
      end
      mem_valid = 1; mem_rd = 9; mem_data = 32'h99;
      #1;
      chk("drain_mem_ready", mem_ready, 1);
      step();
      idle();
      chk("drain_rd_we", rd_we, 1);
      chk("drain_rd_num", rd_num, 9);
      chk("drain_rd_data", rd_data, 32'h99);
      chk("drain_busy_clr", busy, 0);
      chk("drain_halted_pulse", halted, 0);
      step();
      chk("drain_rd_we_low", rd_we, 0);
      chk("drain_halted_pre", halted, 0);
      step();
      chk("halted_rise", halted, 1);
      alu_valid = 1; alu_rd = 3; mem_valid = 1; mem_rd = 4;
      issue_valid = 1; issue_rd = 3; halt_req = 1;
      #1;
      chk("halted_alu_ready", alu_ready, 0);
      chk("halted_mem_ready", mem_ready, 0);
      step();
      idle();
      chk("halted_rd_we", rd_we, 0);
      chk("halted_busy", busy, 0);
      chk("halted_stays", halted, 1);

      // Async reset in DRAIN with a write and a busy bit in flight.
      rst_b = 0;
      #2 rst_b = 1;
      step();
      issue_valid = 1; issue_rd = 10;
      step();
      idle();
      halt_req = 1; alu_valid = 1; alu_rd = 2; alu_data = 32'h22;
      #1;
      chk("rst_alu_ready", alu_ready, 1);
      step();
      idle();
      chk("rst_pre_rd_we", rd_we, 1);
      chk("rst_pre_busy", busy, 32'h400);
      rst_b = 0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_rd_we", rd_we, 0);
      chk("rst_halted", halted, 0);
      chk("rst_rd_num", rd_num, 0);
      #2 rst_b = 1;
      step();
      chk("rst_run_halted", halted, 0);
      halt_req = 1;
      step();
      halt_req = 0;
      chk("quick_halt_t1", halted, 0);
      step();
      chk("quick_halt_t2", halted, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
